// File: rtl/rca_mult_arbiter.sv
// Two-port arbiter/sequencer around a shared rca_add_mult datapath, with registered operands and results.
// Define RCA_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins contention); the default build is round-robin.
`timescale 1ns/1ps

// Mode map: sum_funct=1 adds (carry_option=1 suppresses carries, i.e. XOR);
// sum_funct=0 multiplies (carry_option=1 selects the carry-less product).
module rca_add_mult #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
  input  logic                    sum_funct,
  input  logic                    carry_option,
  output logic [DATA_WIDTH-1:0]   out,
  output logic [2*DATA_WIDTH-1:0] mult_out
);

  localparam int PW = 2 * DATA_WIDTH;

  // Ripple-carry adder across the full product width; kill forces every carry to zero.
  function automatic logic [PW-1:0] rca(input logic [PW-1:0] x, input logic [PW-1:0] y,
                                        input logic kill);
    logic          c;
    logic [PW-1:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < PW; i++) begin
      // NOTE: blocking assignments are correct here: each bit must see the carry of the bit
      // before it within the same evaluation. Clocked state elsewhere uses non-blocking only.
      s[i] = x[i] ^ y[i] ^ c;
      c    = ~kill & ((x[i] & y[i]) | (c & (x[i] ^ y[i])));
    end
    return s;
  endfunction

  logic [PW-1:0] acc;
  logic [PW-1:0] pp;

  always_comb begin
    // NOTE: every variable gets a value before any branch, so no path can infer a latch.
    acc = '0;
    pp  = '0;
    if (sum_funct) begin
      acc = rca({{DATA_WIDTH{1'b0}}, a}, {{DATA_WIDTH{1'b0}}, b}, carry_option);
    end else begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        pp  = b[i] ? ({{DATA_WIDTH{1'b0}}, a} << i) : '0;
        acc = rca(acc, pp, carry_option);
      end
    end
  end

  assign out      = acc[DATA_WIDTH-1:0];
  assign mult_out = acc;

endmodule

module rca_mult_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_sum_funct,
  input  logic [1:0]              req_carry_option,
  input  logic [DATA_WIDTH-1:0]   req_a0,
  input  logic [DATA_WIDTH-1:0]   req_b0,
  input  logic [DATA_WIDTH-1:0]   req_a1,
  input  logic [DATA_WIDTH-1:0]   req_b1,
  output logic [1:0]              resp_valid,
  input  logic [1:0]              resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_out,
  output logic [2*DATA_WIDTH-1:0] resp_mult_out,
  output logic                    busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic                    winner;
  logic                    accept;
  logic                    owner;
  logic                    op_sum_funct;
  logic                    op_carry_option;
  logic [DATA_WIDTH-1:0]   op_a;
  logic [DATA_WIDTH-1:0]   op_b;
  logic [DATA_WIDTH-1:0]   dp_out;
  logic [2*DATA_WIDTH-1:0] dp_mult_out;

`ifdef RCA_ARB_FIXED_PRIO_EN
  // Port 1 only wins when it is the sole requester.
  always_comb winner = (req_valid == 2'b10);
`else
  logic last_grant;

  always_comb begin
    if (req_valid == 2'b11) winner = ~last_grant;
    else                    winner = req_valid[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= winner;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        // Held low during reset so every output is quiet while rst is asserted.
        req_ready[winner] = req_valid[winner] & ~rst;
        accept            = req_valid[winner] & ~rst;
        if (accept) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        resp_valid[owner] = 1'b1;
        if (resp_ready[owner]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner           <= 1'b0;
      op_sum_funct    <= 1'b0;
      op_carry_option <= 1'b0;
      op_a            <= '0;
      op_b            <= '0;
      resp_out        <= '0;
      resp_mult_out   <= '0;
    end else begin
      if (accept) begin
        owner           <= winner;
        op_sum_funct    <= req_sum_funct[winner];
        op_carry_option <= req_carry_option[winner];
        op_a            <= winner ? req_a1 : req_a0;
        op_b            <= winner ? req_b1 : req_b0;
      end
      if (state == EXEC) begin
        resp_out      <= dp_out;
        resp_mult_out <= dp_mult_out;
      end
    end
  end

  rca_add_mult #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_datapath (
    .a            (op_a),
    .b            (op_b),
    .sum_funct    (op_sum_funct),
    .carry_option (op_carry_option),
    .out          (dp_out),
    .mult_out     (dp_mult_out)
  );

  a_resp_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(resp_valid));
  a_ready_idle  : assert property (@(posedge clk) disable iff (rst)
                                   (state != IDLE) |-> (req_ready == 2'b00));

endmodule

// File: tb/tb_rca_mult_arbiter.sv
// Self-checking bench for rca_mult_arbiter: a cycle model of the arbiter plus a result scoreboard.
// Honours RCA_ARB_FIXED_PRIO_EN so the same bench covers both arbitration builds.
`timescale 1ns/1ps

module tb_rca_mult_arbiter;

  localparam int W        = 32;
  localparam int MAX_WAIT = 1000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v0 = 1'b0, v1 = 1'b0, sf0 = 1'b0, sf1 = 1'b0, co0 = 1'b0, co1 = 1'b0;
  logic         rr0 = 1'b1, rr1 = 1'b1;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  logic [1:0]     req_valid, req_ready, req_sum_funct, req_carry_option;
  logic [1:0]     resp_valid, resp_ready;
  logic [W-1:0]   resp_out;
  logic [2*W-1:0] resp_mult_out;
  logic           busy;

  assign req_valid        = {v1, v0};
  assign req_sum_funct    = {sf1, sf0};
  assign req_carry_option = {co1, co0};
  assign resp_ready       = {rr1, rr0};

  always #5 clk = ~clk;

  rca_mult_arbiter #(.DATA_WIDTH(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_sum_funct    (req_sum_funct),
    .req_carry_option (req_carry_option),
    .req_a0           (a0),
    .req_b0           (b0),
    .req_a1           (a1),
    .req_b1           (b1),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_out         (resp_out),
    .resp_mult_out    (resp_mult_out),
    .busy             (busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of the shared datapath, written with plain operators.
  function automatic logic [2*W-1:0] golden(input logic sf, input logic co,
                                            input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] r;
    r = '0;
    if (sf && !co)  r = {{W{1'b0}}, a} + {{W{1'b0}}, b};
    else if (sf)    r = {{W{1'b0}}, a ^ b};
    else if (!co)   r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    else begin
      for (int i = 0; i < W; i++)
        if (b[i]) r = r ^ ({{W{1'b0}}, a} << i);
    end
    return r;
  endfunction

  function automatic logic model_winner(input logic [1:0] v, input logic last);
`ifdef RCA_ARB_FIXED_PRIO_EN
    return (v == 2'b10) | (1'b0 & last);
`else
    if (v == 2'b11) return ~last;
    return v[1];
`endif
  endfunction

  typedef struct {
    logic           owner;
    logic [2*W-1:0] result;
  } exp_t;

  typedef enum {M_IDLE, M_EXEC, M_RESP} mstate_t;

  exp_t           sb[$];
  int             grants[$];
  mstate_t        m_state = M_IDLE;
  logic           m_last  = 1'b1;
  logic           m_owner = 1'b0;
  logic           m_w;
  logic           m_hold  = 1'b0;
  logic [W-1:0]   m_prev_out;
  logic [2*W-1:0] m_prev_mult;
  exp_t           m_e;

  // Cycle model: samples mid-cycle, predicts handshakes and checks every output.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_resp_valid", resp_valid, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_resp_out", resp_out, '0);
      check("rst_resp_mult_out", resp_mult_out, '0);
      m_state = M_IDLE;
      m_last  = 1'b1;
      m_hold  = 1'b0;
      sb.delete();
    end else begin
      case (m_state)
        M_IDLE: begin
          m_w = model_winner(req_valid, m_last);
          check("idle_req_ready", req_ready, req_valid[m_w] ? (m_w ? 2'b10 : 2'b01) : 2'b00);
          check("idle_resp_valid", resp_valid, 2'b00);
          check("idle_busy", busy, 1'b0);
          m_hold = 1'b0;
          if (req_valid[m_w]) begin
            m_e.owner  = m_w;
            m_e.result = m_w ? golden(sf1, co1, a1, b1) : golden(sf0, co0, a0, b0);
            sb.push_back(m_e);
            grants.push_back(int'(m_w));
            m_last  = m_w;
            m_owner = m_w;
            m_state = M_EXEC;
          end
        end
        M_EXEC: begin
          check("exec_req_ready", req_ready, 2'b00);
          check("exec_resp_valid", resp_valid, 2'b00);
          check("exec_busy", busy, 1'b1);
          m_state = M_RESP;
        end
        default: begin
          check("resp_req_ready", req_ready, 2'b00);
          check("resp_valid_owner", resp_valid, m_owner ? 2'b10 : 2'b01);
          check("resp_busy", busy, 1'b1);
          if (sb.size() == 0) begin
            check("sb_underflow", sb.size(), 1);
          end else begin
            check("resp_out", resp_out, sb[0].result[W-1:0]);
            check("resp_mult_out", resp_mult_out, sb[0].result);
            check("resp_sb_owner", sb[0].owner, m_owner);
          end
          if (m_hold) begin
            check("hold_out", resp_out, m_prev_out);
            check("hold_mult_out", resp_mult_out, m_prev_mult);
          end
          m_prev_out  = resp_out;
          m_prev_mult = resp_mult_out;
          m_hold      = 1'b1;
          if (resp_ready[m_owner]) begin
            if (sb.size() != 0) void'(sb.pop_front());
            m_state = M_IDLE;
          end
        end
      endcase
    end
  end

  // Requester: present one operation (called just after a rising edge) and hold it until accepted.
  task automatic issue(input int p, input logic sf, input logic co,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    logic seen;
    int   n;
    seen = 1'b0;
    n    = 0;
    if (p == 0) begin v0 = 1'b1; sf0 = sf; co0 = co; a0 = a; b0 = b; end
    else        begin v1 = 1'b1; sf1 = sf; co1 = co; a1 = a; b1 = b; end
    while (!seen && n < MAX_WAIT) begin
      @(negedge clk);
      seen = (req_ready[p] === 1'b1);
      @(posedge clk);
      #1;
      n++;
    end
    if (p == 0) v0 = 1'b0;
    else        v1 = 1'b0;
    check("accept_in_time", seen, 1'b1);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom());
    endcase
  endfunction

  task automatic random_port(input int p, input int count);
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      issue(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_operand(), pick_operand());
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  int   g0;
  int   n;
  int   exp_g;
  logic found;
  logic rand_done;

  initial begin
    // Reset with every input toggling.
    repeat (5) begin
      @(posedge clk); #1;
      {v0, v1, sf0, sf1, co0, co1, rr0, rr1} = 8'($urandom());
      a0 = $urandom(); b0 = $urandom(); a1 = $urandom(); b1 = $urandom();
    end
    @(posedge clk); #1;
    {v0, v1} = 2'b00;
    rr0 = 1'b1; rr1 = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Contention: port 0 has six jobs, port 1 three, both asserted together.
    g0 = grants.size();
    fork
      for (int k = 0; k < 6; k++) issue(0, 1'b1, 1'b0, W'($urandom()), W'($urandom()));
      for (int k = 0; k < 3; k++) issue(1, 1'b0, 1'b0, W'($urandom()), W'($urandom()));
    join
    repeat (4) begin @(posedge clk); #1; end
    check("contention_count", (grants.size() - g0) >= 9, 1'b1);
    for (int k = 0; k < 6; k++) begin
`ifdef RCA_ARB_FIXED_PRIO_EN
      exp_g = 0;
`else
      exp_g = k % 2;
`endif
      check("contention_grant", (grants.size() > g0 + k) ? grants[g0 + k] : -1, exp_g);
    end

    // Single request on port 0: 3 + 5.
    issue(0, 1'b1, 1'b0, 32'h0000_0003, 32'h0000_0005);
    @(negedge clk);
    check("single_exec_resp_valid", resp_valid, 2'b00);
    @(negedge clk);
    check("single_resp_valid", resp_valid, 2'b01);
    check("single_resp_out", resp_out, 32'h0000_0008);
    check("single_resp_mult_out", resp_mult_out, 64'h8);
    @(posedge clk); #1;
    repeat (2) begin @(posedge clk); #1; end

    // Backpressure on port 1 while port 0 waits.
    rr1 = 1'b0;
    fork
      issue(1, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
      begin
        repeat (3) begin @(posedge clk); #1; end
        issue(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      end
      begin
        found = 1'b0;
        n     = 0;
        while (!found && n < MAX_WAIT) begin
          @(negedge clk);
          found = resp_valid[1];
          n++;
        end
        check("bp_resp_seen", found, 1'b1);
        repeat (10) begin
          @(negedge clk);
          check("bp_req_ready", req_ready, 2'b00);
        end
        @(posedge clk); #1;
        rr1 = 1'b1;
        @(negedge clk);
        check("bp_handshake_valid", resp_valid, 2'b10);
        @(negedge clk);
        check("bp_after_handshake_busy", busy, 1'b0);
      end
    join
    repeat (4) begin @(posedge clk); #1; end

    // Reset during EXEC abandons the operation.
    issue(0, 1'b0, 1'b0, 32'h0000_1000, 32'h0000_0010);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_resp_valid", resp_valid, 2'b00);
      check("post_rst_busy", busy, 1'b0);
    end
    @(posedge clk); #1;
    issue(1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    @(negedge clk);
    @(negedge clk);
    check("fresh_resp_valid", resp_valid, 2'b10);
    check("fresh_resp_mult_out", resp_mult_out, 64'h1_0000_0000);
    @(posedge clk); #1;

    // Randomized operands and modes with random response backpressure.
    rand_done = 1'b0;
    fork
      begin
        fork
          random_port(0, 500);
          random_port(1, 500);
        join
        rand_done = 1'b1;
      end
      while (!rand_done) begin
        @(posedge clk); #1;
        rr0 = ($urandom_range(0, 3) != 0);
        rr1 = ($urandom_range(0, 3) != 0);
      end
    join
    rr0 = 1'b1;
    rr1 = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("sb_drained", sb.size(), 0);
    check("final_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rca_mult_arbiter.md
# rca_mult_arbiter

Two-port round-robin arbiter and sequencer that shares a single `rca_add_mult` instance (configurable adder/carry-less multiplier) between two requesters. It sits between requesters and the shared datapath. Operands are registered before they reach the datapath and results are registered after it, which keeps the datapath's long combinational carry/product path out of requester timing. The block holds one operation in flight at a time, and each response is returned only to the port that issued it.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand width; passed unchanged to the internal `rca_add_mult`.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid[1:0]`  in  2  per-port request valid.
- `req_ready[1:0]`  out  2  per-port request accept.
- `req_sum_funct[1:0]`, `req_carry_option[1:0]`  in  2 each  per-port datapath mode bits.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  `DATA_WIDTH` each  per-port operands.
- `resp_valid[1:0]`  out  2  per-port response valid.
- `resp_ready[1:0]`  in  2  per-port response accept.
- `resp_out`  out  `DATA_WIDTH`  registered `out` of the datapath; shared by both ports and qualified by `resp_valid`.
- `resp_mult_out`  out  `2*DATA_WIDTH`  registered `mult_out` of the datapath; shared and qualified by `resp_valid`.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- **State machine:** IDLE -> EXEC -> RESP -> IDLE.
- **IDLE:**
  - The arbiter picks a winner among asserted `req_valid` bits.
  - `req_ready[w]` is asserted for the winner only. It is combinational from `req_valid` and the state.
  - On `req_valid[w] & req_ready[w]`, the block captures the winner's mode bits and operands into the operand registers, stores the owner `w`, and moves to EXEC.
- **EXEC:**
  - The operand registers drive the datapath.
  - At the end of the cycle, the block captures the datapath `out` and `mult_out` into the result registers and moves to RESP.
- **RESP:**
  - `resp_valid[owner]` is 1 and the other `resp_valid` bit is 0.
  - On `resp_ready[owner]`, the block moves to IDLE.
  - `resp_ready` of the non-owner port is ignored.
- **Round robin:**
  - A `last_grant` register updates on every accepted request.
  - When both ports are valid, the port that is not `last_grant` wins.
  - When only one port is valid, that port wins regardless of `last_grant`.
  - `last_grant` resets to 1, so port 0 wins the first contention.
- **Outside IDLE:** `req_ready` is all zeros.
- **Requester rules:**
  - A requester holds its mode bits and operands stable while `req_valid` is high and `req_ready` is low.
  - A requester may drop `req_valid` before it is accepted; nothing is captured.
- **Width rule:** results pass through unmodified. No truncation, sign handling or reduction is applied in this block.

## Timing
- **Reset values:** state=IDLE, `req_ready`=0 except as derived combinationally in IDLE, `resp_valid`=0, `resp_out`=0, `resp_mult_out`=0, `busy`=0, `last_grant`=1, operand registers=0.
- **Latency:** accept in cycle T; `resp_valid` is high from cycle T+2.
- **Throughput:**
  - With `resp_ready` held high, there is at most one accept every 3 cycles.
  - The response handshake in cycle T+2 returns the block to IDLE, and the next accept can occur in cycle T+3.
- **Response hold:** `resp_out`, `resp_mult_out` and `resp_valid` stay stable until they are accepted, however long `resp_ready` stays low.
- **Reset mid-operation:**
  - Asserting `rst` in EXEC or RESP abandons the operation immediately.
  - The abandoned operation produces no response after reset is released.
- **Both ports valid every cycle:** grants alternate 0, 1, 0, 1, ...
- **Simultaneous events:** a new `req_valid` that rises in the same cycle as a response handshake is considered in the next cycle, once the state is IDLE.

## Configuration
- Macro `RCA_ARB_FIXED_PRIO_EN`.
- **Defined:** fixed priority applies.
  - Port 0 always wins when both ports are valid.
  - The `last_grant` register is not implemented.
- **Undefined (default):** round-robin arbitration as described above.
- All other behaviour and timing are identical in both builds.

## Test plan
- **Reset:** assert `rst` with all inputs toggling -> every output is 0, `busy`=0, and the first grant goes to port 0.
- **Single request:** port 0 only; a=32'h0000_0003, b=32'h0000_0005, `sum_funct`=1, `carry_option`=0, `resp_ready`=1 -> `req_ready[0]` in cycle 0, `resp_valid[0]` in cycle 2, `resp_valid[1]`=0; `resp_out` and `resp_mult_out` equal a standalone `rca_add_mult` fed the same inputs.
- **Contention:** both ports valid continuously for 6 operations -> grant order 0, 1, 0, 1, 0, 1; with `RCA_ARB_FIXED_PRIO_EN` the order is 0, 0, 0, ... and port 1 is never granted.
- **Backpressure:** `resp_ready[1]`=0 for 10 cycles after `resp_valid[1]` rises -> outputs are stable and `req_ready`=2'b00 throughout; the response handshake occurs on the cycle `resp_ready[1]` rises.
- **Reset mid-operation:** assert `rst` during EXEC -> after release, no `resp_valid` and state is IDLE; a fresh request completes normally with latency 2.
- **Randomized operands:** all four mode combinations, 1000 random operand pairs -> every response matches the golden model and is routed to the correct owner port.
